// File: rtl/kb_uart_bridge.sv
// kb_uart_bridge
// Buffers words from the keyboard interface in a small FIFO and paces them
// out to the UART transmitter one byte per send/busy handshake, MSB first.
// Build option: define KB_BRIDGE_HEX_EN to send each word as uppercase ASCII
// hex characters followed by a single space instead of raw bytes.
module kb_uart_bridge #(
    parameter int  DATA_W     = 8,
    parameter int  FIFO_DEPTH = 16,
    localparam int AW         = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_tick,
    input  logic              tx_busy,
    output logic [7:0]        tx_data,
    output logic              tx_send,
    output logic [AW:0]       fifo_level,
    output logic              overflow,
    input  logic              clr_overflow
);

`ifdef KB_BRIDGE_HEX_EN
    // One character per nibble plus the trailing space.
    localparam int CHARS = DATA_W / 4 + 1;
    localparam int SHIFT = 4;
`else
    localparam int CHARS = DATA_W / 8;
    localparam int SHIFT = 8;
`endif
    localparam int          CW           = $clog2(CHARS + 1);
    localparam logic [AW:0] FULL_LEVEL   = (AW + 1)'(FIFO_DEPTH);
    localparam logic [3:0]  TIMEOUT_LAST = 4'd14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        WAIT_HI,
        WAIT_LO
    } state_t;

`ifdef KB_BRIDGE_HEX_EN
    // Uppercase ASCII for one hex digit.
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction
`endif

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              push;
    logic              pop;
    logic              full;

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] next_shift;
    logic [CW-1:0]     chars;
    logic [CW-1:0]     next_chars;
    logic [3:0]        timeout_cnt;
    logic [3:0]        next_timeout_cnt;
    logic              enter_send;
    logic [7:0]        next_byte;

    // A pop only happens when LOAD hands the head word to the shifter, so a
    // full FIFO can still accept a word in that same cycle.
    assign full = (fifo_level == FULL_LEVEL);
    assign pop  = (state == LOAD) && !tx_busy;
    assign push = in_tick && (!full || pop);

    // FIFO storage; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers and occupancy; pointers wrap naturally at the power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + (AW + 1)'(1);
                2'b01:   fifo_level <= fifo_level - (AW + 1)'(1);
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (in_tick && !push) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

    // FSM state, shifter, character count and busy-timeout counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shift_reg   <= '0;
            chars       <= '0;
            timeout_cnt <= '0;
        end else begin
            state       <= next_state;
            shift_reg   <= next_shift;
            chars       <= next_chars;
            timeout_cnt <= next_timeout_cnt;
        end
    end

    // Next-state logic; SEND is only ever entered when the UART reports idle.
    always_comb begin
        next_state       = state;
        next_shift       = shift_reg;
        next_chars       = chars;
        next_timeout_cnt = timeout_cnt;
        case (state)
            IDLE: begin
                if (fifo_level != '0) begin
                    next_state = LOAD;
                end
            end
            LOAD: begin
                if (!tx_busy) begin
                    next_shift = mem[rd_ptr];
                    next_chars = CW'(CHARS);
                    next_state = SEND;
                end
            end
            SEND: begin
                next_timeout_cnt = 4'd0;
                next_state       = WAIT_HI;
            end
            WAIT_HI: begin
                if (tx_busy || (timeout_cnt == TIMEOUT_LAST)) begin
                    next_state = WAIT_LO;
                end else begin
                    next_timeout_cnt = timeout_cnt + 4'd1;
                end
            end
            WAIT_LO: begin
                if (!tx_busy) begin
                    next_shift = shift_reg << SHIFT;
                    next_chars = chars - CW'(1);
                    if (chars == CW'(1)) begin
                        next_state = IDLE;
                    end else begin
                        next_state = SEND;
                    end
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Byte that will be presented on the upcoming SEND, taken from the
    // shifter contents as they will be after this edge.
    always_comb begin
        enter_send = (next_state == SEND) && (state != SEND);
`ifdef KB_BRIDGE_HEX_EN
        if (next_chars == CW'(1)) begin
            next_byte = 8'h20;
        end else begin
            next_byte = hex_char(next_shift[DATA_W-1 -: 4]);
        end
`else
        next_byte = next_shift[DATA_W-1 -: 8];
`endif
    end

    // Registered UART outputs; tx_data holds its value until the next SEND.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tx_send <= 1'b0;
            tx_data <= 8'h00;
        end else begin
            tx_send <= enter_send;
            if (enter_send) begin
                tx_data <= next_byte;
            end
        end
    end

endmodule

// File: tb/tb_kb_uart_bridge.sv
// tb_kb_uart_bridge
// Scoreboard bench for kb_uart_bridge: two instances (8-bit/depth 4 and
// 16-bit/depth 16), each driven into a simple UART busy model.
module tb_kb_uart_bridge;
    localparam int BUSY_CYCLES = 10;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cycle = 0;
    int   n_pass  = 0;
    int   n_total = 0;

    logic [7:0]  in_data_a = '0;
    logic        in_tick_a = 1'b0;
    logic        tx_busy_a;
    logic [7:0]  tx_data_a;
    logic        tx_send_a;
    logic [2:0]  level_a;
    logic        overflow_a;
    logic        clr_a = 1'b0;

    logic [15:0] in_data_b = '0;
    logic        in_tick_b = 1'b0;
    logic        tx_busy_b;
    logic [7:0]  tx_data_b;
    logic        tx_send_b;
    logic [4:0]  level_b;
    logic        overflow_b;
    logic        clr_b = 1'b0;

    logic hold_a = 1'b0;
    logic mute_a = 1'b0;
    int   busy_cnt_a;
    int   busy_cnt_b;

    logic [7:0] exp_a[$];
    logic [7:0] obs_a[$];
    logic       bv_a[$];
    int         t_a[$];
    logic [7:0] exp_b[$];
    logic [7:0] obs_b[$];
    logic       bv_b[$];
    int         t_b[$];

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    kb_uart_bridge #(.DATA_W(8), .FIFO_DEPTH(4)) dut_a (
        .clk(clk), .reset(reset), .in_data(in_data_a), .in_tick(in_tick_a),
        .tx_busy(tx_busy_a), .tx_data(tx_data_a), .tx_send(tx_send_a),
        .fifo_level(level_a), .overflow(overflow_a), .clr_overflow(clr_a)
    );

    kb_uart_bridge #(.DATA_W(16), .FIFO_DEPTH(16)) dut_b (
        .clk(clk), .reset(reset), .in_data(in_data_b), .in_tick(in_tick_b),
        .tx_busy(tx_busy_b), .tx_data(tx_data_b), .tx_send(tx_send_b),
        .fifo_level(level_b), .overflow(overflow_b), .clr_overflow(clr_b)
    );

    // UART models: busy for BUSY_CYCLES after each send strobe.
    always @(posedge clk or posedge reset) begin
        if (reset) busy_cnt_a <= 0;
        else if (tx_send_a && !mute_a) busy_cnt_a <= BUSY_CYCLES;
        else if (busy_cnt_a > 0) busy_cnt_a <= busy_cnt_a - 1;
    end
    assign tx_busy_a = hold_a || (busy_cnt_a != 0);

    always @(posedge clk or posedge reset) begin
        if (reset) busy_cnt_b <= 0;
        else if (tx_send_b) busy_cnt_b <= BUSY_CYCLES;
        else if (busy_cnt_b > 0) busy_cnt_b <= busy_cnt_b - 1;
    end
    assign tx_busy_b = (busy_cnt_b != 0);

    // Output monitors, sampled on the falling edge.
    always @(negedge clk) begin
        if (tx_send_a) begin
            obs_a.push_back(tx_data_a);
            bv_a.push_back(tx_busy_a);
            t_a.push_back(cycle);
        end
        if (tx_send_b) begin
            obs_b.push_back(tx_data_b);
            bv_b.push_back(tx_busy_b);
            t_b.push_back(cycle);
        end
    end

    // Expected byte stream for one word, in the configured output format.
    function automatic void add_expected(input int which, input logic [31:0] w, input int width);
        logic [7:0] b;
        logic [3:0] nib;
`ifdef KB_BRIDGE_HEX_EN
        for (int i = width / 4 - 1; i >= 0; i--) begin
            nib = 4'((w >> (4 * i)) & 32'hF);
            b = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h41 + {4'h0, nib} - 8'd10);
            if (which == 0) exp_a.push_back(b); else exp_b.push_back(b);
        end
        if (which == 0) exp_a.push_back(8'h20); else exp_b.push_back(8'h20);
`else
        nib = 4'h0;
        for (int i = width / 8 - 1; i >= 0; i--) begin
            b = 8'((w >> (8 * i)) & 32'hFF);
            if (which == 0) exp_a.push_back(b); else exp_b.push_back(b);
        end
`endif
    endfunction

    task automatic tick_a(input logic [7:0] d);
        in_data_a = d;
        in_tick_a = 1'b1;
        @(negedge clk);
        in_tick_a = 1'b0;
    endtask

    task automatic tick_b(input logic [15:0] d);
        in_data_b = d;
        in_tick_b = 1'b1;
        @(negedge clk);
        in_tick_b = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({tx_send_a, tx_data_a, level_a, overflow_a} !== 13'd0)
            $display("[TB] FAIL reset_a got send=%b data=%h level=%0d ovf=%b expected all 0",
                     tx_send_a, tx_data_a, level_a, overflow_a);
        else n_pass++;
        n_total++;
        if ({tx_send_b, tx_data_b, level_b, overflow_b} !== 15'd0)
            $display("[TB] FAIL reset_b got send=%b data=%h level=%0d ovf=%b expected all 0",
                     tx_send_b, tx_data_b, level_b, overflow_b);
        else n_pass++;
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        int t0, first_t;
        logic [7:0] e, o, last;
        logic bsy;
        t0 = cycle + 1;
        add_expected(0, 32'h1C, 8);
        last = exp_a[$];
        tick_a(8'h1C);
        for (int k = 0; k < 400 && obs_a.size() < exp_a.size(); k++) @(negedge clk);
        repeat (30) @(negedge clk);
        first_t = (t_a.size() > 0) ? t_a[0] : -1;
        n_total++;
        if (first_t !== t0 + 2) $display("[TB] FAIL single_latency got cycle %0d expected %0d", first_t, t0 + 2);
        else n_pass++;
        n_total++;
        if (obs_a.size() !== exp_a.size()) $display("[TB] FAIL single_count got %0d expected %0d", obs_a.size(), exp_a.size());
        else n_pass++;
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front(); bsy = bv_a.pop_front(); void'(t_a.pop_front());
            n_total++;
            if (o !== e) $display("[TB] FAIL single_byte got %h expected %h", o, e); else n_pass++;
            n_total++;
            if (bsy !== 1'b0) $display("[TB] FAIL single_send_busy got %b expected 0", bsy); else n_pass++;
        end
        n_total++;
        if (tx_data_a !== last) $display("[TB] FAIL single_hold got %h expected %h", tx_data_a, last);
        else n_pass++;
        exp_a.delete(); obs_a.delete(); bv_a.delete(); t_a.delete();
    endtask

    task automatic test_word16();
        int ts[$];
        logic [7:0] e, o;
        logic bsy;
        add_expected(1, 32'hE075, 16);
        tick_b(16'hE075);
        for (int k = 0; k < 400 && obs_b.size() < exp_b.size(); k++) @(negedge clk);
        repeat (30) @(negedge clk);
        ts = t_b;
        n_total++;
        if (obs_b.size() !== exp_b.size()) $display("[TB] FAIL word16_count got %0d expected %0d", obs_b.size(), exp_b.size());
        else n_pass++;
        n_total++;
        if (ts.size() < 2 || (ts[1] - ts[0]) < BUSY_CYCLES + 1)
            $display("[TB] FAIL word16_gap got %0d pulses gap %0d expected gap >= %0d",
                     ts.size(), (ts.size() < 2) ? 0 : ts[1] - ts[0], BUSY_CYCLES + 1);
        else n_pass++;
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front(); o = obs_b.pop_front(); bsy = bv_b.pop_front(); void'(t_b.pop_front());
            n_total++;
            if (o !== e) $display("[TB] FAIL word16_byte got %h expected %h", o, e); else n_pass++;
            n_total++;
            if (bsy !== 1'b0) $display("[TB] FAIL word16_send_busy got %b expected 0", bsy); else n_pass++;
        end
        exp_b.delete(); obs_b.delete(); bv_b.delete(); t_b.delete();
    endtask

    task automatic test_overflow();
        logic [7:0] e, o;
        hold_a = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            if (i <= 4) add_expected(0, 32'(i), 8);
            tick_a(8'(i));
        end
        n_total++;
        if (level_a !== 3'd4) $display("[TB] FAIL ovf_level got %0d expected 4", level_a); else n_pass++;
        n_total++;
        if (overflow_a !== 1'b1) $display("[TB] FAIL ovf_flag got %b expected 1", overflow_a); else n_pass++;
        n_total++;
        if (obs_a.size() !== 0) $display("[TB] FAIL ovf_no_send got %0d pulses expected 0", obs_a.size()); else n_pass++;
        hold_a = 1'b0;
        for (int k = 0; k < 600 && obs_a.size() < exp_a.size(); k++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_total++;
        if (obs_a.size() !== exp_a.size()) $display("[TB] FAIL ovf_count got %0d expected %0d", obs_a.size(), exp_a.size());
        else n_pass++;
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            n_total++;
            if (o !== e) $display("[TB] FAIL ovf_byte got %h expected %h", o, e); else n_pass++;
        end
        n_total++;
        if (overflow_a !== 1'b1) $display("[TB] FAIL ovf_sticky got %b expected 1", overflow_a); else n_pass++;
        clr_a = 1'b1;
        @(negedge clk);
        clr_a = 1'b0;
        n_total++;
        if (overflow_a !== 1'b0) $display("[TB] FAIL ovf_clear got %b expected 0", overflow_a); else n_pass++;
        exp_a.delete(); obs_a.delete(); bv_a.delete(); t_a.delete();
    endtask

    task automatic test_full_pop();
        logic [7:0] e, o;
        hold_a = 1'b1;
        for (int i = 8'h11; i <= 8'h14; i++) begin
            add_expected(0, 32'(i), 8);
            tick_a(8'(i));
        end
        n_total++;
        if (level_a !== 3'd4) $display("[TB] FAIL fullpop_pre_level got %0d expected 4", level_a); else n_pass++;
        hold_a = 1'b0;
        add_expected(0, 32'h15, 8);
        tick_a(8'h15);
        n_total++;
        if (level_a !== 3'd4) $display("[TB] FAIL fullpop_level got %0d expected 4", level_a); else n_pass++;
        n_total++;
        if (overflow_a !== 1'b0) $display("[TB] FAIL fullpop_ovf got %b expected 0", overflow_a); else n_pass++;
        for (int k = 0; k < 800 && obs_a.size() < exp_a.size(); k++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_total++;
        if (obs_a.size() !== exp_a.size()) $display("[TB] FAIL fullpop_count got %0d expected %0d", obs_a.size(), exp_a.size());
        else n_pass++;
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            n_total++;
            if (o !== e) $display("[TB] FAIL fullpop_byte got %h expected %h", o, e); else n_pass++;
        end
        exp_a.delete(); obs_a.delete(); bv_a.delete(); t_a.delete();
    endtask

    task automatic test_reset_mid();
        logic [7:0] e, o;
        tick_b(16'h1234);
        for (int i = 1; i <= 5; i++) tick_b(16'h2000 + 16'(i));
        repeat (3) @(negedge clk);
        n_total++;
        if (level_b !== 5'd5) $display("[TB] FAIL rstmid_pre_level got %0d expected 5", level_b); else n_pass++;
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({tx_send_b, tx_data_b, level_b, overflow_b} !== 15'd0)
            $display("[TB] FAIL rstmid_clear got send=%b data=%h level=%0d ovf=%b expected all 0",
                     tx_send_b, tx_data_b, level_b, overflow_b);
        else n_pass++;
        reset = 1'b0;
        exp_b.delete(); obs_b.delete(); bv_b.delete(); t_b.delete();
        repeat (40) @(negedge clk);
        n_total++;
        if (obs_b.size() !== 0) $display("[TB] FAIL rstmid_idle got %0d pulses expected 0", obs_b.size()); else n_pass++;
        add_expected(1, 32'hABCD, 16);
        tick_b(16'hABCD);
        for (int k = 0; k < 400 && obs_b.size() < exp_b.size(); k++) @(negedge clk);
        repeat (30) @(negedge clk);
        n_total++;
        if (obs_b.size() !== exp_b.size()) $display("[TB] FAIL rstmid_count got %0d expected %0d", obs_b.size(), exp_b.size());
        else n_pass++;
        while (exp_b.size() > 0 && obs_b.size() > 0) begin
            e = exp_b.pop_front(); o = obs_b.pop_front();
            n_total++;
            if (o !== e) $display("[TB] FAIL rstmid_byte got %h expected %h", o, e); else n_pass++;
        end
        exp_b.delete(); obs_b.delete(); bv_b.delete(); t_b.delete();
    endtask

`ifdef KB_BRIDGE_HEX_EN
    task automatic test_hex_timeout();
        int ts[$];
        logic [7:0] e, o;
        mute_a = 1'b1;
        add_expected(0, 32'h1C, 8);
        tick_a(8'h1C);
        for (int k = 0; k < 400 && obs_a.size() < exp_a.size(); k++) @(negedge clk);
        repeat (30) @(negedge clk);
        ts = t_a;
        n_total++;
        if (obs_a.size() !== 3) $display("[TB] FAIL hex_count got %0d expected 3", obs_a.size()); else n_pass++;
        for (int i = 1; i < ts.size(); i++) begin
            n_total++;
            if ((ts[i] - ts[i-1]) < 16 || (ts[i] - ts[i-1]) > 18)
                $display("[TB] FAIL hex_timeout_gap got %0d expected 16..18", ts[i] - ts[i-1]);
            else n_pass++;
        end
        while (exp_a.size() > 0 && obs_a.size() > 0) begin
            e = exp_a.pop_front(); o = obs_a.pop_front();
            n_total++;
            if (o !== e) $display("[TB] FAIL hex_byte got %h expected %h", o, e); else n_pass++;
        end
        mute_a = 1'b0;
        exp_a.delete(); obs_a.delete(); bv_a.delete(); t_a.delete();
    endtask
`endif

    // Watchdog so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Test sequence.
    initial begin
        test_reset();
        test_single_byte();
        test_word16();
        test_overflow();
        test_full_pop();
        test_reset_mid();
`ifdef KB_BRIDGE_HEX_EN
        test_hex_timeout();
`endif
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
